// File: rtl/sysctrl_pkg.sv
// Shared command codes, status constants and helpers for the MCU system-control slave.
package sysctrl_pkg;

    typedef enum logic [7:0] {
        CMD_STATUS   = 8'h00,
        CMD_LEDS     = 8'h01,
        CMD_COLOR    = 8'h02,
        CMD_BUTTONS  = 8'h03,
        CMD_VAR_WR   = 8'h04,
        CMD_IRQ_STAT = 8'h05,
        CMD_VAR_RD   = 8'h06,
        CMD_IRQ_MASK = 8'h07
    } cmd_e;

    localparam logic [7:0] STATUS_MAGIC0 = 8'h5C;
    localparam logic [7:0] STATUS_MAGIC1 = 8'h42;
    localparam logic [7:0] IF_VERSION    = 8'h01;

    localparam logic [3:0] STATE_IDLE = 4'd0;
    localparam logic [3:0] STATE_MAX  = 4'd15;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sysctrl_irq.sv
// Edge-latched interrupt controller: rising edges set pending bits, MCU acks clear them,
// and the mask only gates the request line and status readback.
module sysctrl_irq #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] i_int_in,
    input  logic               i_ack_en,
    input  logic [NUM_IRQ-1:0] i_ack_bits,
    input  logic               i_mask_we,
    input  logic [NUM_IRQ-1:0] i_mask_bits,
    output logic [NUM_IRQ-1:0] o_status,
    output logic               o_int_n
);

    logic [NUM_IRQ-1:0] r_in_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_ack;
    logic [NUM_IRQ-1:0] w_pending_next;

    assign w_rise = i_int_in & ~r_in_q;
    assign w_ack  = i_ack_en ? i_ack_bits : '0;
    // OR-ing the new edges in last lets a set beat a simultaneous ack.
    assign w_pending_next = (r_pending & ~w_ack) | w_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_q    <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_in_q    <= i_int_in;
            r_pending <= w_pending_next;
            if (i_mask_we) begin
                r_mask <= i_mask_bits;
            end
        end
    end

    assign o_status = r_pending & r_mask;
    assign o_int_n  = ~|o_status;

endmodule

// File: rtl/sysctrl_gen.sv
// Generic MCU system-control slave: byte-framed command decoder, config var bank,
// LED/RGB registers and an interrupt controller.
module sysctrl_gen
    import sysctrl_pkg::*;
#(
    parameter logic [7:0]              CORE_ID      = 8'h02,
    parameter int                      NUM_VARS     = 16,
    parameter logic [NUM_VARS*8-1:0]   VAR_DEFAULTS = '0,
    parameter int                      NUM_IRQ      = 8,
    parameter int                      NUM_BTN      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  data_in_strobe,
    input  logic                  data_in_start,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  int_out_n,
    input  logic [NUM_IRQ-1:0]    int_in,
    input  logic [NUM_BTN-1:0]    buttons,
    output logic [1:0]            leds,
    output logic [23:0]           color,
    output logic [NUM_VARS*8-1:0] vars,
    output logic [NUM_VARS-1:0]   var_wr
);

    localparam logic [8:0] NUM_VARS_W = 9'(NUM_VARS);

    logic [3:0]  r_state, w_state_next;
    logic [7:0]  r_cmd, w_cmd_next;
    logic [7:0]  r_idx, w_idx_next;
    logic [7:0]  r_data_out, w_data_out_next;
    logic [1:0]  r_leds, w_leds_next;
    logic [23:0] r_color, w_color_next;
    logic        w_var_we;
    logic        w_ack_en;
    logic        w_mask_we;
    logic        w_payload;
    logic [7:0]  w_idx_inc;
    logic [7:0]  w_rd_first;
    logic [7:0]  w_rd_next;
    logic [7:0]  w_btn_byte;
    logic [7:0]  w_irq_byte;

    logic [7:0]          r_slot [NUM_VARS];
    logic [NUM_VARS-1:0] r_var_wr;
    logic [NUM_IRQ-1:0]  w_irq_status;

    assign w_payload = data_in_strobe & ~data_in_start & (r_state != STATE_IDLE);
    assign w_idx_inc = r_idx + 8'd1;

    // Slot lookup for both the first readback byte (addressed by the payload itself)
    // and burst continuation; unmatched addresses fall through to zero.
    always_comb begin
        w_rd_first = '0;
        w_rd_next  = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (data_in == 8'(i)) begin
                w_rd_first = r_slot[i];
            end
            if (w_idx_inc == 8'(i)) begin
                w_rd_next = r_slot[i];
            end
        end
    end

    always_comb begin
        w_btn_byte = '0;
        w_irq_byte = '0;
        w_btn_byte[NUM_BTN-1:0] = buttons;
        w_irq_byte[NUM_IRQ-1:0] = w_irq_status;
    end

    always_comb begin
        w_state_next    = r_state;
        w_cmd_next      = r_cmd;
        w_idx_next      = r_idx;
        w_data_out_next = r_data_out;
        w_leds_next     = r_leds;
        w_color_next    = r_color;
        w_var_we        = 1'b0;
        w_ack_en        = 1'b0;
        w_mask_we       = 1'b0;

        if (data_in_strobe && data_in_start) begin
            w_cmd_next   = data_in;
            w_state_next = 4'd1;
        end else if (w_payload) begin
            if (r_state != STATE_MAX) begin
                w_state_next = r_state + 4'd1;
            end
            case (r_cmd)
                CMD_STATUS: begin
                    case (r_state)
                        4'd1:    w_data_out_next = STATUS_MAGIC0;
                        4'd2:    w_data_out_next = STATUS_MAGIC1;
                        4'd3:    w_data_out_next = CORE_ID;
                        4'd4:    w_data_out_next = 8'(NUM_VARS);
                        4'd5:    w_data_out_next = IF_VERSION;
                        default: w_data_out_next = 8'h00;
                    endcase
                end
                CMD_LEDS: begin
                    if (r_state == 4'd1) begin
                        w_leds_next = data_in[1:0];
                    end
                end
                CMD_COLOR: begin
                    case (r_state)
                        4'd1:    w_color_next[15:8]  = bit_rev8(data_in);
                        4'd2:    w_color_next[7:0]   = bit_rev8(data_in);
                        4'd3:    w_color_next[23:16] = bit_rev8(data_in);
                        default: ;
                    endcase
                end
                CMD_BUTTONS: begin
                    w_data_out_next = w_btn_byte;
                end
                CMD_VAR_WR: begin
                    if (r_state == 4'd1) begin
                        w_idx_next = data_in;
                    end else if (r_state == 4'd2 && {1'b0, r_idx} < NUM_VARS_W) begin
                        w_var_we = 1'b1;
                    end
                end
                CMD_IRQ_STAT: begin
                    w_data_out_next = w_irq_byte;
                    w_ack_en        = (r_state == 4'd1);
                end
                CMD_VAR_RD: begin
                    if (r_state == 4'd1) begin
                        w_idx_next      = data_in;
                        w_data_out_next = w_rd_first;
                    end else begin
                        w_idx_next      = w_idx_inc;
                        w_data_out_next = w_rd_next;
                    end
                end
                CMD_IRQ_MASK: begin
                    w_mask_we = (r_state == 4'd1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= STATE_IDLE;
            r_cmd      <= '0;
            r_idx      <= '0;
            r_data_out <= '0;
            r_leds     <= '0;
            r_color    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cmd      <= w_cmd_next;
            r_idx      <= w_idx_next;
            r_data_out <= w_data_out_next;
            r_leds     <= w_leds_next;
            r_color    <= w_color_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_slot
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_slot[gi]   <= VAR_DEFAULTS[8*gi +: 8];
                    r_var_wr[gi] <= 1'b0;
                end else begin
                    r_var_wr[gi] <= w_var_we && (r_idx == 8'(gi));
                    if (w_var_we && (r_idx == 8'(gi))) begin
                        r_slot[gi] <= data_in;
                    end
                end
            end
            assign vars[8*gi +: 8] = r_slot[gi];
        end
    endgenerate

    sysctrl_irq #(
        .NUM_IRQ(NUM_IRQ)
    ) u_irq (
        .clk         (clk),
        .rst_n       (reset_n),
        .i_int_in    (int_in),
        .i_ack_en    (w_ack_en),
        .i_ack_bits  (data_in[NUM_IRQ-1:0]),
        .i_mask_we   (w_mask_we),
        .i_mask_bits (data_in[NUM_IRQ-1:0]),
        .o_status    (w_irq_status),
        .o_int_n     (int_out_n)
    );

    assign data_out = r_data_out;
    assign leds     = r_leds;
    assign color    = r_color;
    assign var_wr   = r_var_wr;

endmodule

// File: doc/sysctrl_gen.md
Name: sysctrl_gen

Overview:
Generic MCU system-control slave that replaces the per-core control block. It decodes byte-framed commands arriving over the MCU link (start and strobe qualifiers). It holds a parametrised bank of OSD configuration bytes with readback, plus LED and RGB colour registers. It also contains an edge-latched, maskable interrupt controller. The block sits between the MCU link deserialiser and the core top level, and each core selects its variable bank width and core ID via parameters.

Parameters:
CORE_ID, 8'h02, value returned in status byte 3.
NUM_VARS, 16, number of 8-bit config slots (1..64).
VAR_DEFAULTS, all-zero NUM_VARS*8 vector, per-slot reset value; slot i is bits [8i+7:8i].
NUM_IRQ, 8, number of interrupt sources (1..8).
NUM_BTN, 2, number of button inputs (1..8).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
data_in_strobe  in  1  one-cycle byte-valid pulse
data_in_start  in  1  qualifies the strobed byte as a command byte
data_in  in  8  byte from MCU
data_out  out  8  byte to MCU, registered
int_out_n  out  1  active-low interrupt request to MCU
int_in  in  NUM_IRQ  level interrupt sources
buttons  in  NUM_BTN  raw button levels
leds  out  2  MCU-controlled LEDs
color  out  24  RGB for ws2812, {R,G,B}
vars  out  NUM_VARS*8  flat config bank
var_wr  out  NUM_VARS  one-cycle pulse when the slot is written

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=0, command=0, idx=0, data_out=0, leds=0, color=0, vars=VAR_DEFAULTS, var_wr=0, pending=0, mask=all ones, in_q=0.
- Framing:
  - strobe&start: command<=data_in, state<=1.
  - strobe&!start with state!=0: execute (command,state), then state increments and saturates at 15.
  - Strobes while state==0 are ignored.
- data_out is registered on the strobe. A byte set while handling transfer k is presented for transfer k+1.
- CMD 0 status: state 1..5 -> data_out = 5C, 42, CORE_ID, NUM_VARS, 8'h01 (interface version). State >=6 -> 00.
- CMD 1: state 1 -> leds<=data_in[1:0].
- CMD 2: states 1, 2, 3 -> G, B, R. The byte is bit-reversed before storing to color[15:8], [7:0], [23:16].
- CMD 3: every payload byte -> data_out = buttons, zero-extended to 8 bits.
- CMD 4 write var:
  - state 1 -> idx<=data_in.
  - state 2 -> if idx<NUM_VARS, slot[idx]<=data_in and var_wr[idx]=1 for exactly one cycle.
  - idx>=NUM_VARS is silently dropped.
  - State >=3: no effect.
- CMD 5 irq status/ack:
  - Every payload byte -> data_out = pending & mask, zero-extended, sampled before this cycle's ack.
  - state 1 -> pending &= ~data_in[NUM_IRQ-1:0].
- CMD 6 read var:
  - state 1 -> idx<=data_in; data_out = slot[data_in], or 00 if out of range.
  - Each later state: idx increments and data_out = next slot, giving burst readback. Out-of-range reads return 00. idx wraps at 255.
- CMD 7 irq mask: state 1 -> mask<=data_in[NUM_IRQ-1:0].
- Unknown command: payload ignored, data_out unchanged.
- IRQ:
  - in_q<=int_in every cycle; rising edge (int_in & ~in_q) sets pending bit.
  - A set coinciding with an ack of the same bit: set wins.
  - int_out_n = ~|(pending & mask), combinational from registers.
  - A masked source still latches pending.
- New start mid-command aborts the old command, with no partial side effects beyond bytes already applied.
- var_wr is 0 in every cycle except a CMD 4 state-2 valid write.

Decomposition:
- sysctrl_pkg: command codes (CMD_STATUS..CMD_IRQ_MASK), status magic 5C/42, IF_VERSION, bit-reverse function.
- Sub-module sysctrl_irq (NUM_IRQ): edge detect, pending, mask, ack, int_out_n.
- Top-level command decoder and var bank stay in sysctrl_gen.

Test Plan:
- Reset defaults: NUM_VARS=4, VAR_DEFAULTS=32'h03020100 -> after reset_n release, vars=03020100, int_out_n=1, leds=0.
- Status: start 00 then four payload strobes -> data_out sequence 5C, 42, 02, 04.
- Var write/read: CMD4 {02,AB} -> var_wr=0100 for one cycle and slot2=AB. CMD6 {01,xx,xx} -> data_out 01 (slot1 default), AB, 03. CMD4 {09,55} -> no change, var_wr stays 0.
- Colour: CMD2 {80,01,FF} -> color=FF0180 after bit-reverse (R=FF, G=01, B=80).
- IRQ: pulse int_in[3] -> int_out_n=0. CMD5 ack 08 -> pending clears and int_out_n=1. Rising edge of bit3 in the ack cycle -> pending stays set.
- Mask/abort: CMD7 00 -> int_in edge keeps int_out_n=1 while CMD5 returns 00. CMD7 FF -> int_out_n=0. Start mid-CMD4 after idx byte -> no var write occurs.
